// File: rtl/bitscan_datapath.sv
// -----------------------------------------------------------------------------
// bitscan_datapath
//   Bit-serial scan datapath controlled by an external 3-state one-hot
//   sequencer (t0 idle/load, t1 skip zero bits, t2 count one bits). It shifts
//   a WIDTH-bit operand out MSB-first and accumulates its population count and
//   its leading-zero count. The status bits x and z go back to the sequencer,
//   which uses them to choose its next state.
//
// Ports
//   clk        clock, every register updates on the rising edge
//   rst_n      asynchronous active-low reset
//   t0/t1/t2   one-hot sequencer state
//   s          start, sampled only while t0
//   din        operand, captured on t0 & s
//   x          A[WIDTH-1] | (C == 0)
//   z          C == 0
//   ones_cnt   popcount result
//   lz_cnt     leading-zero count (WIDTH for a zero operand)
//   res_valid  results valid, cleared by the next load
//   done       one-cycle completion pulse
// -----------------------------------------------------------------------------
module bitscan_datapath #(
   parameter int WIDTH = 8,
   parameter int CW    = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             t0,
   input  logic             t1,
   input  logic             t2,
   input  logic             s,
   input  logic [WIDTH-1:0] din,
   output logic             x,
   output logic             z,
   output logic [CW-1:0]    ones_cnt,
   output logic [CW-1:0]    lz_cnt,
   output logic             res_valid,
   output logic             done
);

   logic [WIDTH-1:0] a;     // operand shift register, MSB is the current bit
   logic [CW-1:0]    c;     // bits still to be consumed
   logic             seen;  // a 1 bit has already been consumed

   // Once C reaches zero, x is forced high. That routes t1 to its
   // non-consuming path and keeps C from ever being decremented past zero.
   assign z = (c == '0);
   assign x = a[WIDTH-1] | z;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a         <= '0;
         c         <= '0;
         seen      <= 1'b0;
         ones_cnt  <= '0;
         lz_cnt    <= '0;
         res_valid <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case ({t0, t1, t2})
            3'b100: begin
               if (s) begin
                  a         <= din;
                  c         <= CW'(WIDTH);
                  seen      <= 1'b0;
                  ones_cnt  <= '0;
                  lz_cnt    <= '0;
                  res_valid <= 1'b0;
               end
            end
            3'b010: begin
               // Consume a 0 bit. It counts as leading only until the first 1.
               if (!x) begin
                  a <= {a[WIDTH-2:0], 1'b0};
                  c <= c - CW'(1);
                  if (!seen) lz_cnt <= lz_cnt + CW'(1);
               end
            end
            3'b001: begin
               if (z) begin
                  res_valid <= 1'b1;
                  done      <= 1'b1;
               end else if (x) begin
                  a        <= {a[WIDTH-2:0], 1'b0};
                  c        <= c - CW'(1);
                  ones_cnt <= ones_cnt + CW'(1);
                  seen     <= 1'b1;
               end
            end
            default: begin
               // Illegal or empty state encodings hold every register.
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bitscan_datapath.sv
module tb_bitscan_datapath;

   localparam int W  = 8;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          t0, t1, t2;
   logic          s;
   logic [W-1:0]  din;
   logic          x, z;
   logic [CW-1:0] ones_cnt, lz_cnt;
   logic          res_valid, done;

   int checks = 0;
   int errors = 0;

   // Sequencer paired with the datapath. ovr replaces its outputs with
   // ovr_t (used to inject illegal encodings) and freezes its state.
   localparam logic [1:0] S_IDLE = 2'd0, S_SKIP = 2'd1, S_CNT = 2'd2;
   logic [1:0] st;
   logic       ovr;
   logic [2:0] ovr_t;

   always #5 clk = ~clk;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) st <= S_IDLE;
      else if (!ovr) begin
         case (st)
            S_IDLE:  if (s) st <= S_SKIP;
            S_SKIP:  if (x) st <= S_CNT;
            S_CNT:   if (z) st <= S_IDLE; else if (!x) st <= S_SKIP;
            default: st <= S_IDLE;
         endcase
      end
   end

   always_comb begin
      if (ovr) {t0, t1, t2} = ovr_t;
      else     {t0, t1, t2} = {st == S_IDLE, st == S_SKIP, st == S_CNT};
   end

   bitscan_datapath #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .t0(t0), .t1(t1), .t2(t2), .s(s), .din(din),
      .x(x), .z(z), .ones_cnt(ones_cnt), .lz_cnt(lz_cnt),
      .res_valid(res_valid), .done(done)
   );

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   // Reference: popcount, leading zeros and scan occupancy from the operand.
   // Occupancy = one cycle per bit + the final z cycle + one cycle for every
   // change of required state in the list [skip, per-bit state, count].
   function automatic void ref_model(input logic [W-1:0] d, output int ones,
                                     output int lz, output int occ);
      int seq[$];
      int changes;
      ones = 0;
      lz   = W;
      seq.push_back(1);
      for (int unsigned k = 0; k < W; k++) begin
         if (d[W-1-k]) begin
            ones++;
            if (lz == W) lz = int'(k);
            seq.push_back(2);
         end else begin
            seq.push_back(1);
         end
      end
      seq.push_back(2);
      changes = 0;
      for (int unsigned k = 1; k < seq.size(); k++)
         if (seq[k] != seq[k-1]) changes++;
      occ = W + 1 + changes;
   endfunction

   // Called at a negedge with the sequencer idle. Loads d, follows the scan,
   // and checks the results on the done cycle. It returns on that cycle, so a
   // following call loads on the same t0 cycle as the completed result.
   task automatic run_op(input logic [W-1:0] d, input int e_ones, input int e_lz,
                         input int e_occ, input bit mid_s, input bit ill);
      int  occ = 0;
      bit  used = 0, done_seen = 0, finished = 0;
      din = d;
      s   = 1'b1;
      @(negedge clk);
      s = 1'b0;
      chk("load_res_valid", res_valid, 0);
      chk("load_ones", ones_cnt, 0);
      chk("load_lz", lz_cnt, 0);
      for (int k = 0; k < 200; k++) begin
         if (ovr) ovr = 1'b0;
         if (t1 | t2) begin
            if (ill && !used && occ == 3) begin
               ovr_t = 3'b011;
               ovr   = 1'b1;
               used  = 1;
            end else begin
               occ++;
               if (done) done_seen = 1;
               if (mid_s) s = 1'($urandom_range(0, 1));
            end
         end else begin
            finished = 1;
            break;
         end
         @(negedge clk);
      end
      s = 1'b0;
      if (!finished) begin
         errors++;
         checks++;
         $display("FAIL scan_timeout din=%0h actual=%0d required=%0d", d, occ, e_occ);
      end
      chk($sformatf("occ_%0h", d), occ, e_occ);
      chk("done_early", done_seen, 0);
      chk($sformatf("done_%0h", d), done, 1);
      chk($sformatf("valid_%0h", d), res_valid, 1);
      chk($sformatf("ones_%0h", d), ones_cnt, e_ones);
      chk($sformatf("lz_%0h", d), lz_cnt, e_lz);
   endtask

   typedef struct {
      logic [W-1:0] din;
      int           ones;
      int           lz;
      int           occ;
      bit           mid_s;
      bit           ill;
   } vec_t;

   vec_t tbl[7];

   initial begin
      int e_ones, e_lz, e_occ;
      logic [W-1:0] d;
      bit reached;

      // A5 has four runs of ones: 8 bits + 4 skip->count + 3 count->skip + 1.
      tbl[0] = '{8'h00, 0, 8, 10, 0, 0};
      tbl[1] = '{8'hFF, 8, 0, 10, 0, 0};
      tbl[2] = '{8'h02, 1, 6, 12, 0, 0};
      tbl[3] = '{8'hA5, 4, 0, 16, 1, 0};
      tbl[4] = '{8'h10, 1, 3, 12, 0, 1};
      tbl[5] = '{8'h80, 1, 0, 12, 0, 0};
      tbl[6] = '{8'h01, 1, 7, 10, 1, 1};

      rst_n = 1'b0; s = 1'b0; din = '0; ovr = 1'b0; ovr_t = '0;
      #3;
      chk("rst_ones", ones_cnt, 0);
      chk("rst_lz", lz_cnt, 0);
      chk("rst_valid", res_valid, 0);
      chk("rst_done", done, 0);
      chk("rst_x", x, 1);
      chk("rst_z", z, 1);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("idle_valid", res_valid, 0);
      chk("idle_done", done, 0);
      chk("idle_z", z, 1);
      chk("idle_t0", t0, 1);

      for (int unsigned i = 0; i < 7; i++)
         run_op(tbl[i].din, tbl[i].ones, tbl[i].lz, tbl[i].occ, tbl[i].mid_s, tbl[i].ill);

      // Results hold while idle with s low.
      repeat (5) @(negedge clk);
      chk("hold_valid", res_valid, 1);
      chk("hold_done", done, 0);
      chk("hold_ones", ones_cnt, 1);
      chk("hold_lz", lz_cnt, 7);

      // Illegal t0=t1=1 for one cycle while idle.
      ovr_t = 3'b110;
      ovr   = 1'b1;
      @(negedge clk);
      ovr = 1'b0;
      chk("ill_valid", res_valid, 1);
      chk("ill_ones", ones_cnt, 1);
      chk("ill_lz", lz_cnt, 7);
      chk("ill_z", z, 1);
      chk("ill_done", done, 0);

      for (int i = 0; i < 40; i++) begin
         d = W'($urandom);
         ref_model(d, e_ones, e_lz, e_occ);
         run_op(d, e_ones, e_lz, e_occ, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         chk("sum_bound", (int'(ones_cnt) + int'(lz_cnt) <= W) ? 1 : 0, 1);
      end

      // Reset in the middle of a 3C scan, during a count-one cycle.
      @(negedge clk);
      din = 8'h3C;
      s   = 1'b1;
      @(negedge clk);
      s = 1'b0;
      reached = 0;
      for (int k = 0; k < 50; k++) begin
         if (t2) begin
            reached = 1;
            break;
         end
         @(negedge clk);
      end
      chk("reach_t2", reached, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_ones", ones_cnt, 0);
      chk("mid_rst_lz", lz_cnt, 0);
      chk("mid_rst_valid", res_valid, 0);
      chk("mid_rst_done", done, 0);
      chk("mid_rst_x", x, 1);
      chk("mid_rst_z", z, 1);
      @(negedge clk);
      rst_n = 1'b1;
      reached = 0;
      repeat (12) begin
         @(negedge clk);
         if (done) reached = 1;
      end
      chk("no_done_after_rst", reached, 0);
      chk("post_rst_valid", res_valid, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
